// File: rtl/fma_dot_seq_pkg.sv
// fma_dot_seq_pkg: shared fixed-point defaults and sequencer state encoding
package fma_dot_seq_pkg;
    localparam int Q_DEF = 15;
    localparam int N_DEF = 32;
    typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/fma_dot_seq_fma.sv
// fma_dot_seq_fma: sign-magnitude Q-format a + b*c, magnitude wraps, no saturation
module fma_dot_seq_fma
    import fma_dot_seq_pkg::*;
#(
    parameter int Q = Q_DEF,
    parameter int N = N_DEF
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic [N-1:0] i_c,
    output logic [N-1:0] o_y
);
    logic [2*N-3:0] w_prod;
    logic [N-2:0]   w_pm;
    logic [N-2:0]   w_am;
    logic [N-2:0]   w_mag;
    logic           w_ps;
    logic           w_as;
    logic           w_ge;
    logic           w_sign;

    assign w_prod = {{(N-1){1'b0}}, i_b[N-2:0]} * {{(N-1){1'b0}}, i_c[N-2:0]};
    assign w_pm   = (N-1)'(w_prod >> Q);
    assign w_ps   = i_b[N-1] ^ i_c[N-1];
    assign w_as   = i_a[N-1];
    assign w_am   = i_a[N-2:0];
    assign w_ge   = w_am >= w_pm;
    assign w_mag  = (w_as == w_ps) ? w_am + w_pm : (w_ge ? w_am - w_pm : w_pm - w_am);
    assign w_sign = (w_as == w_ps || w_ge) ? w_as : w_ps;
    // a zero magnitude is always reported as +0
    assign o_y    = {w_sign && |w_mag, w_mag};
endmodule

// File: rtl/fma_dot_seq.sv
// fma_dot_seq: streams (x,w) pairs through one fma stage to form bias + sum(x*w)
module fma_dot_seq
    import fma_dot_seq_pkg::*;
#(
    parameter int Q     = Q_DEF,
    parameter int N     = N_DEF,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [N-1:0]     bias,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     x,
    input  logic [N-1:0]     w,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     result,
    output logic             busy
);
    state_t           r_state;
    state_t           w_next;
    logic [N-1:0]     r_acc;
    logic [N-1:0]     w_fma;
    logic [LEN_W-1:0] r_cnt;
    logic             w_beat;
    logic             w_load;

    fma_dot_seq_fma #(.Q(Q), .N(N)) u_fma (
        .i_a(r_acc),
        .i_b(x),
        .i_c(w),
        .o_y(w_fma)
    );

    assign w_load    = r_state == IDLE && start;
    assign w_beat    = r_state == ACC && in_valid;
    assign in_ready  = r_state == ACC;
    assign out_valid = r_state == DONE;
    assign busy      = r_state != IDLE;
    assign result    = r_acc;

    always_comb begin
        w_next = r_state;
        if (w_load) w_next = (len == '0) ? DONE : ACC;
        if (w_beat && r_cnt == LEN_W'(1)) w_next = DONE;
        if (r_state == DONE && out_ready) w_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_load) begin
                r_acc <= bias;
                r_cnt <= len;
            end else if (w_beat) begin
                r_acc <= w_fma;
                r_cnt <= r_cnt - LEN_W'(1);
            end
        end
    end
endmodule

// File: doc/fma_dot_seq.md
FMA_DOT_SEQ -- requirements
Module: fma_dot_seq

Interface
REQ-001 SHALL have parameter Q, default 15, fractional bit count of the fixed-point format.
REQ-002 SHALL have parameter N, default 32, total word width: sign-magnitude, MSB = sign, N-1 magnitude bits.
REQ-003 SHALL have parameter LEN_W, default 8, width of the vector-length field.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 start  input  1  one-cycle request to begin a dot product; sampled in IDLE only.
REQ-008 len  input  LEN_W  number of (x,w) pairs; sampled with start.
REQ-009 bias  input  N  initial accumulator value; sampled with start.
REQ-010 in_valid  input  1  x/w pair present.
REQ-011 in_ready  output  1  block accepts a pair this cycle.
REQ-012 x  input  N  activation operand.
REQ-013 w  input  N  weight operand.
REQ-014 out_valid  output  1  result present.
REQ-015 out_ready  input  1  consumer accepts the result.
REQ-016 result  output  N  final accumulator value.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 SHALL implement states IDLE, ACC and DONE.
REQ-019 IDLE, start=1, len!=0: acc<=bias, cnt<=len, next state ACC.
REQ-020 IDLE, start=1, len==0: acc<=bias, next state DONE (result = bias).
REQ-021 ACC: in_ready=1; a beat is in_valid&&in_ready.
REQ-022 On each beat: acc <= fma(a=acc, b=x, c=w) using Q/N fixed-point multiply-add semantics; cnt <= cnt-1.
REQ-023 A beat with cnt==1 SHALL move the state to DONE; cycles without a beat SHALL hold acc, cnt and state.
REQ-024 Throughput: one pair per cycle; out_valid rises on the cycle after the final beat.
REQ-025 DONE: out_valid=1, result=acc, in_ready=0; out_valid&&out_ready moves the state to IDLE.
REQ-026 result SHALL hold stable while out_valid=1 and out_ready=0.
REQ-027 start SHALL be ignored outside IDLE; a start arriving in the same cycle as the DONE->IDLE handshake SHALL also be ignored.
REQ-028 The arithmetic path SHALL NOT saturate: overflow wraps exactly as the fma stage produces it.
REQ-029 in_ready and out_valid SHALL be decoded from registered state only, with no combinational path from in_valid or out_ready.

Reset
REQ-030 rst_n low SHALL force, asynchronously: state=IDLE, acc=0, cnt=0, in_ready=0, out_valid=0, busy=0, result=0.
REQ-031 Reset asserted mid-operation SHALL abandon the partial sum; no out_valid pulse follows reset deassertion.

Structure
REQ-032 Q, N defaults and the state encoding SHALL reside in the shared fixed-point package/include.
REQ-033 The multiply-add datapath SHALL be one instance of the existing fma sub-module; the sequencer contains no other arithmetic besides the cnt decrement.

Verification
REQ-034 bias=0, len=3, three beats of x=0x00008000 (1.0), w=0x00004000 (0.5), in_valid held high -> out_valid on the 4th cycle after start, result=0x0000C000 (1.5).
REQ-035 start with len=0, bias=0x00010000 -> out_valid the next cycle, result=0x00010000, in_ready never asserted.
REQ-036 bias=0x00008000, len=1, x=0x80008000 (-1.0), w=0x00010000 (2.0) -> result=0x80008000 (-1.0).
REQ-037 len=4 with in_valid toggling 1,0,1,0,1,1 and out_ready held low for 5 cycles -> exactly 4 beats accumulated; result stable until the handshake, then IDLE.
REQ-038 start pulsed during ACC, then rst_n pulsed low after 2 of 4 beats -> the start has no effect; after reset all outputs are 0 and the next start with bias=0, len=1, x=w=0x00008000 gives 0x00008000.
